// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_sbox_pkg
// Brief  : Shared types, sizes and GF(2^8) helpers for the shared S-box lanes
// Rev    : 1.0  initial release
// ============================================================================
package aes_sbox_pkg;

  localparam int BYTES_PER_BLOCK = 16;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KW = 1'b1
  } owner_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] e;
    r  = 8'h01;
    sq = x;
    e  = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] a);
    return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_inv_lut.sv
`default_nettype none
// ============================================================================
// Module : sbox_inv_lut
// Brief  : Combined forward/inverse AES S-box lane sharing one GF inverter
// Rev    : 1.0  initial release
// ============================================================================
module sbox_inv_lut
  import aes_sbox_pkg::*;
(
  input  logic       encrypt,
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  logic [7:0] w_pre;
  logic [7:0] w_inv;

  always_comb begin
    w_pre    = encrypt ? byte_in : affine_inv(byte_in);
    w_inv    = gf_inv(w_pre);
    byte_out = encrypt ? affine_fwd(w_inv) : w_inv;
  end

endmodule
`default_nettype wire

// File: rtl/sbox_share_sched.sv
`default_nettype none
// ============================================================================
// Module : sbox_share_sched
// Brief  : Time-shares NUM_SBOX S-box lanes between cipher state and key word
// Rev    : 1.0  initial release
// ============================================================================
module sbox_share_sched
  import aes_sbox_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic         st_encrypt,
  input  logic [127:0] st_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_data,
  output logic         kw_rsp_valid,
  input  logic         kw_rsp_ready,
  output logic [31:0]  kw_rsp_data,
  output logic         busy
);

  localparam int c_st_passes = BYTES_PER_BLOCK / NUM_SBOX;
  localparam int c_kw_passes = (NUM_SBOX >= BYTES_PER_WORD) ? 1 : BYTES_PER_WORD / NUM_SBOX;
  localparam logic [4:0] c_st_last = 5'(c_st_passes - 1);
  localparam logic [4:0] c_kw_last = 5'(c_kw_passes - 1);

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
        NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
      $error("sbox_share_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t       r_state;
  state_t       w_state_next;
  owner_t       r_owner;
  owner_t       r_last_grant;
  logic         r_encrypt;
  logic [4:0]   r_pass_cnt;
  logic [127:0] r_st_data;
  logic [127:0] r_st_res;
  logic [31:0]  r_kw_data;
  logic [31:0]  r_kw_res;

  logic         w_grant_st;
  logic         w_grant_kw;
  logic         w_last_pass;
  logic         w_rsp_hs;

  logic [4:0]   w_idx      [NUM_SBOX];
  logic         w_lane_act [NUM_SBOX];
  logic [7:0]   w_lane_in  [NUM_SBOX];
  logic [7:0]   w_lane_out [NUM_SBOX];

  // Round-robin: on a tie the requester that did not win last time gets ready.
  always_comb begin
    w_grant_st  = st_req_valid && (!kw_req_valid || (r_last_grant == OWN_KW));
    w_grant_kw  = kw_req_valid && (!st_req_valid || (r_last_grant == OWN_ST));
    w_last_pass = (r_owner == OWN_ST) ? (r_pass_cnt == c_st_last)
                                      : (r_pass_cnt == c_kw_last);
    w_rsp_hs    = (r_state == DONE) &&
                  ((r_owner == OWN_ST) ? st_rsp_ready : kw_rsp_ready);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (st_req_ready || kw_req_ready) w_state_next = RUN;
      RUN:     if (w_last_pass) w_state_next = DONE;
      DONE:    if (w_rsp_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    st_req_ready = !reset && (r_state == IDLE) && w_grant_st;
    kw_req_ready = !reset && (r_state == IDLE) && w_grant_kw;
    st_rsp_valid = (r_state == DONE) && (r_owner == OWN_ST);
    kw_rsp_valid = (r_state == DONE) && (r_owner == OWN_KW);
    busy         = (r_state != IDLE);
  end

  assign st_rsp_data = r_st_res;
  assign kw_rsp_data = r_kw_res;

  // Byte-select: lane l handles byte pass_cnt*NUM_SBOX+l; idle lanes see zero.
  always_comb begin
    for (int l = 0; l < NUM_SBOX; l++) begin
      w_idx[l]      = r_pass_cnt * 5'(NUM_SBOX) + 5'(l);
      w_lane_act[l] = 1'b0;
      w_lane_in[l]  = 8'h00;
      if (r_state == RUN) begin
        if (r_owner == OWN_ST) begin
          w_lane_act[l] = 1'b1;
          w_lane_in[l]  = r_st_data[{w_idx[l][3:0], 3'b000} +: 8];
        end else if (w_idx[l] < 5'(BYTES_PER_WORD)) begin
          w_lane_act[l] = 1'b1;
          w_lane_in[l]  = r_kw_data[{w_idx[l][1:0], 3'b000} +: 8];
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
      sbox_inv_lut u_sbox (
        .encrypt  (r_encrypt),
        .byte_in  (w_lane_in[l]),
        .byte_out (w_lane_out[l])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWN_ST;
      r_last_grant <= OWN_KW;
      r_encrypt    <= 1'b1;
      r_pass_cnt   <= 5'd0;
      r_st_data    <= 128'd0;
      r_st_res     <= 128'd0;
      r_kw_data    <= 32'd0;
      r_kw_res     <= 32'd0;
    end else begin
      if (st_req_ready) begin
        r_st_data  <= st_data;
        r_owner    <= OWN_ST;
        r_encrypt  <= st_encrypt;
        r_pass_cnt <= 5'd0;
      end else if (kw_req_ready) begin
        r_kw_data  <= kw_data;
        r_owner    <= OWN_KW;
        r_encrypt  <= 1'b1;
        r_pass_cnt <= 5'd0;
      end

      if (r_state == RUN) begin
        r_pass_cnt <= r_pass_cnt + 5'd1;
        for (int l = 0; l < NUM_SBOX; l++) begin
          if (w_lane_act[l]) begin
            if (r_owner == OWN_ST) begin
              r_st_res[{w_idx[l][3:0], 3'b000} +: 8] <= w_lane_out[l];
            end else begin
              r_kw_res[{w_idx[l][1:0], 3'b000} +: 8] <= w_lane_out[l];
            end
          end
        end
      end

      if (w_rsp_hs) begin
        r_last_grant <= r_owner;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_sbox_share_sched
// Brief  : Directed self-checking bench, four instances with NUM_SBOX 4/1/2/16
// Rev    : 1.0  initial release
// ============================================================================
module tb_sbox_share_sched;

  localparam logic [7:0] SBOX_TAB [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] ST_PT = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] ST_CT = 128'h1628c14beaaceec4f533fc1bc3938263;

  // Expected latencies per instance: NUM_SBOX = 4, 1, 2, 16.
  localparam int ST_LAT [4] = '{4, 16, 8, 1};
  localparam int KW_LAT [4] = '{1, 4, 2, 1};

  logic         clk = 1'b0;
  logic         reset;
  logic         st_req_valid [4];
  logic         st_req_ready [4];
  logic         st_encrypt   [4];
  logic [127:0] st_data      [4];
  logic         st_rsp_valid [4];
  logic         st_rsp_ready [4];
  logic [127:0] st_rsp_data  [4];
  logic         kw_req_valid [4];
  logic         kw_req_ready [4];
  logic [31:0]  kw_data      [4];
  logic         kw_rsp_valid [4];
  logic         kw_rsp_ready [4];
  logic [31:0]  kw_rsp_data  [4];
  logic         busy         [4];

  logic [7:0]   inv_tab [256];
  int           checks = 0;
  int           errors = 0;

  logic [127:0] sd;
  logic [31:0]  kd;
  logic         leak;
  int           lat;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      sbox_share_sched #(
        .NUM_SBOX (g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 2 : 16)
      ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .st_req_valid (st_req_valid[g]),
        .st_req_ready (st_req_ready[g]),
        .st_encrypt   (st_encrypt[g]),
        .st_data      (st_data[g]),
        .st_rsp_valid (st_rsp_valid[g]),
        .st_rsp_ready (st_rsp_ready[g]),
        .st_rsp_data  (st_rsp_data[g]),
        .kw_req_valid (kw_req_valid[g]),
        .kw_req_ready (kw_req_ready[g]),
        .kw_data      (kw_data[g]),
        .kw_rsp_valid (kw_rsp_valid[g]),
        .kw_rsp_ready (kw_rsp_ready[g]),
        .kw_rsp_data  (kw_rsp_data[g]),
        .busy         (busy[g])
      );
    end
  endgenerate

  task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] gold_st(input logic [127:0] d, input logic enc);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = enc ? SBOX_TAB[d[8*i +: 8]] : inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] gold_kw(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX_TAB[d[8*i +: 8]];
    return r;
  endfunction

  task automatic st_txn(input int d, input logic enc, input logic [127:0] din,
                        input logic [127:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    st_req_valid[d] = 1'b1;
    st_encrypt[d]   = enc;
    st_data[d]      = din;
    st_rsp_ready[d] = 1'b0;
    #1 chk_bit("st_req_ready", st_req_ready[d], 1'b1);
    @(posedge clk);
    #1 st_req_valid[d] = 1'b0;
    n = 0;
    @(negedge clk);
    chk_bit("st_busy", busy[d], 1'b1);
    while (st_rsp_valid[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_int("st_latency", n, exp_lat);
    chk_vec("st_rsp_data", st_rsp_data[d], exp);
    chk_bit("st_kw_quiet", kw_rsp_valid[d], 1'b0);
    st_rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 st_rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk_bit("st_rsp_drop", st_rsp_valid[d], 1'b0);
    chk_vec("st_data_hold", st_rsp_data[d], exp);
  endtask

  task automatic kw_txn(input int d, input logic [31:0] din, input logic [31:0] exp,
                        input int exp_lat);
    int n;
    @(negedge clk);
    kw_req_valid[d] = 1'b1;
    kw_data[d]      = din;
    kw_rsp_ready[d] = 1'b0;
    #1 chk_bit("kw_req_ready", kw_req_ready[d], 1'b1);
    @(posedge clk);
    #1 kw_req_valid[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (kw_rsp_valid[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_int("kw_latency", n, exp_lat);
    chk_vec("kw_rsp_data", {96'd0, kw_rsp_data[d]}, {96'd0, exp});
    chk_bit("kw_st_quiet", st_rsp_valid[d], 1'b0);
    kw_rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 kw_rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk_bit("kw_rsp_drop", kw_rsp_valid[d], 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      st_req_valid[d] = 1'b0; st_encrypt[d] = 1'b1; st_data[d] = '0; st_rsp_ready[d] = 1'b0;
      kw_req_valid[d] = 1'b0; kw_data[d] = '0; kw_rsp_ready[d] = 1'b0;
    end
    for (int i = 0; i < 256; i++) inv_tab[SBOX_TAB[i]] = 8'(i);

    // Reset state; requests held high must not see ready while in reset.
    st_req_valid[0] = 1'b1;
    kw_req_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_st_ready", st_req_ready[0], 1'b0);
    chk_bit("rst_kw_ready", kw_req_ready[0], 1'b0);
    for (int d = 0; d < 4; d++) begin
      chk_bit("rst_st_valid", st_rsp_valid[d], 1'b0);
      chk_bit("rst_kw_valid", kw_rsp_valid[d], 1'b0);
      chk_bit("rst_busy", busy[d], 1'b0);
      chk_vec("rst_st_data", st_rsp_data[d], 128'd0);
      chk_vec("rst_kw_data", {96'd0, kw_rsp_data[d]}, 128'd0);
    end
    st_req_valid[0] = 1'b0;
    kw_req_valid[0] = 1'b0;
    reset = 1'b0;

    // Known-answer vectors on NUM_SBOX=4.
    st_txn(0, 1'b1, ST_PT, ST_CT, 4);
    st_txn(0, 1'b0, ST_CT, ST_PT, 4);
    kw_txn(0, 32'h093c4fcf, 32'h01eb848a, 1);

    // Both requesters held valid from reset: ST first, then strict alternation.
    pulse_reset();
    st_rsp_ready[0] = 1'b1;
    kw_rsp_ready[0] = 1'b1;
    st_encrypt[0]   = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      sd = {4{32'h0f1e2d3c + 32'(t)}};
      kd = 32'h093c4fcf + 32'(t);
      st_req_valid[0] = 1'b1;
      kw_req_valid[0] = 1'b1;
      st_data[0]      = sd;
      kw_data[0]      = kd;
      #1;
      chk_bit("arb_st_ready", st_req_ready[0], (t % 2) == 0);
      chk_bit("arb_kw_ready", kw_req_ready[0], (t % 2) != 0);
      @(posedge clk);
      lat  = 0;
      leak = 1'b0;
      @(negedge clk);
      while ((((t % 2) == 0) ? st_rsp_valid[0] : kw_rsp_valid[0]) !== 1'b1 && lat < 64) begin
        if ((((t % 2) == 0) ? kw_rsp_valid[0] : st_rsp_valid[0]) !== 1'b0) leak = 1'b1;
        @(negedge clk);
        lat++;
      end
      if ((((t % 2) == 0) ? kw_rsp_valid[0] : st_rsp_valid[0]) !== 1'b0) leak = 1'b1;
      chk_int("arb_latency", lat, ((t % 2) == 0) ? 4 : 1);
      chk_bit("arb_other_quiet", leak, 1'b0);
      if ((t % 2) == 0) chk_vec("arb_st_data", st_rsp_data[0], gold_st(sd, 1'b1));
      else              chk_vec("arb_kw_data", {96'd0, kw_rsp_data[0]}, {96'd0, gold_kw(kd)});
    end
    @(negedge clk);
    st_req_valid[0] = 1'b0;
    kw_req_valid[0] = 1'b0;
    st_rsp_ready[0] = 1'b0;
    kw_rsp_ready[0] = 1'b0;

    // Consumer stalls for 5 cycles while the key schedule keeps requesting.
    @(negedge clk);
    st_req_valid[0] = 1'b1;
    st_data[0]      = ST_PT;
    st_encrypt[0]   = 1'b1;
    @(posedge clk);
    #1;
    st_req_valid[0] = 1'b0;
    kw_req_valid[0] = 1'b1;
    kw_data[0]      = 32'h12345678;
    lat = 0;
    @(negedge clk);
    while (st_rsp_valid[0] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk_int("stall_latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      chk_bit("stall_valid", st_rsp_valid[0], 1'b1);
      chk_vec("stall_data", st_rsp_data[0], ST_CT);
      chk_bit("stall_kw_ready", kw_req_ready[0], 1'b0);
      chk_bit("stall_busy", busy[0], 1'b1);
      @(negedge clk);
    end
    st_rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 st_rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk_bit("stall_rsp_drop", st_rsp_valid[0], 1'b0);
    chk_bit("stall_kw_next", kw_req_ready[0], 1'b1);
    chk_vec("stall_data_hold", st_rsp_data[0], ST_CT);
    kw_req_valid[0] = 1'b0;

    // Reset in the middle of a 16-pass substitution discards it.
    @(negedge clk);
    st_req_valid[1] = 1'b1;
    st_encrypt[1]   = 1'b1;
    st_data[1]      = ST_PT;
    st_rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 st_req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("midrst_busy_before", busy[1], 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_bit("midrst_busy", busy[1], 1'b0);
    chk_bit("midrst_valid", st_rsp_valid[1], 1'b0);
    chk_vec("midrst_data", st_rsp_data[1], 128'd0);
    leak = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (st_rsp_valid[1] !== 1'b0) leak = 1'b1;
    end
    chk_bit("midrst_no_rsp", leak, 1'b0);
    st_rsp_ready[1] = 1'b0;

    // Every byte in both directions, plus every byte through the key path.
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 16; k++) begin
        for (int j = 0; j < 16; j++) sd[8*j +: 8] = 8'(16*k + j);
        st_txn(d, 1'b1, sd, gold_st(sd, 1'b1), ST_LAT[d]);
        st_txn(d, 1'b0, sd, gold_st(sd, 1'b0), ST_LAT[d]);
      end
      for (int k = 0; k < 64; k++) begin
        for (int j = 0; j < 4; j++) kd[8*j +: 8] = 8'(4*k + j);
        kw_txn(d, kd, gold_kw(kd), KW_LAT[d]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
